register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of each register and of each data port.
REQ-003 Parameter ADDR_W, default 5, SHALL set the address width; depth SHALL be 2**ADDR_W (32) entries.
REQ-004 Port clk, input, 1 bit: clock; all writes occur on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous active-low reset; 0 clears all entries.
REQ-006 Port w_enable, input, 1 bit: write enable, sampled at the rising edge of clk.
REQ-007 Port data_addr, input, ADDR_W bits: write address.
REQ-008 Port data_in, input, DATA_W bits: write data.
REQ-009 Port data_addr1, input, ADDR_W bits: read port 1 address.
REQ-010 Port data_addr2, input, ADDR_W bits: read port 2 address.
REQ-011 Port data_out1, output, DATA_W bits: read port 1 data.
REQ-012 Port data_out2, output, DATA_W bits: read port 2 data.

Function
REQ-013 Storage SHALL be 2**ADDR_W registers of DATA_W bits each.
REQ-014 Write: at a rising clk edge with reset=1 and w_enable=1, entry[data_addr] SHALL take data_in; no other entry SHALL change.
REQ-015 With w_enable=0, a clock edge SHALL leave all entries unchanged.
REQ-016 Entry 0 SHALL be hardwired to zero: writes to address 0 are ignored, and reads of address 0 SHALL return 0.
REQ-017 Reads SHALL be combinational and asynchronous: data_outN = entry[data_addrN] with zero-cycle latency.
REQ-018 The two read ports SHALL be independent; both may address the same entry and SHALL then return the same value.
REQ-019 Same-address write and read in the same cycle: the read port SHALL show the old value before the edge and the new value after the edge, with no write-first bypass.
REQ-020 Every write SHALL store full-width data; there SHALL be no byte enables, and there SHALL be no truncation for DATA_W-bit data.
REQ-021 Writes SHALL be accepted every cycle; there SHALL be no handshake and no busy state.

Reset
REQ-022 reset=0 SHALL clear every entry to 0 immediately, independent of clk.
REQ-023 While reset=0, data_out1 and data_out2 SHALL be 0 for any address.
REQ-024 While reset=0, writes SHALL be suppressed even if w_enable=1.
REQ-025 After reset is released (reset 0->1), the first write SHALL occur at the next rising clk edge with w_enable=1.
REQ-026 A reset asserted in the same cycle as a write SHALL win: the entry SHALL read 0.

Structure
REQ-027 A shared package SHALL hold DATA_W, ADDR_W, the derived DEPTH, and the zero-register index constant (0).
REQ-028 The block SHALL be a single module containing the storage array, the write decoder, and two read multiplexers; no sub-module is required.
REQ-029 If a sub-module is used, it SHALL be a single read-mux module named regfile_read_port, instantiated twice.
REQ-030 The storage SHALL be an addressable array, so that a bench can probe entry[i] hierarchically.

Verification
REQ-031 Reset: pulse reset=0, then read all 32 addresses on both ports -> every read SHALL return 32'h00000000.
REQ-032 Basic write: write 32'hFFFFFFFF to address 4 with w_enable=1, set data_addr2=4 -> data_out2 SHALL be 32'hFFFFFFFF after the edge.
REQ-033 Enable gating: with w_enable=0 and data_in=32'h12345678 at address 7, apply 3 clock edges -> data_out1 at address 7 SHALL remain 0.
REQ-034 Zero register: write 32'hFFFFFFFF to address 0, read data_addr1=0 -> data_out1 SHALL be 0.
REQ-035 Dual read: write 32'hA5A5A5A5 to address 31 and 32'h5A5A5A5A to address 1, read both at once -> SHALL return those values; then set data_addr1=data_addr2=31 -> both outputs SHALL be 32'hA5A5A5A5.
REQ-036 Asynchronous reset mid-operation: with address 4 holding 32'hFFFFFFFF, drive reset=0 between clock edges -> data_out2 at address 4 SHALL drop to 0 immediately, and SHALL stay 0 after reset=1 until address 4 is rewritten.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the 2-read / 1-write register file.
package register_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read multiplexer; address 0 and an active reset both read as zero.
module regfile_read_port
    import register_file_pkg::*;
#(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] entries_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = '0;
        if (rst_n_i && (addr_i != ADDR_W'(ZERO_REG))) begin
            data_o = entries_i[addr_i];
        end
    end

endmodule

// File: rtl/register_file.sv
// Register file: one synchronous write port, two asynchronous read ports, entry 0 hardwired to zero.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_W = register_file_pkg::DATA_W,
    parameter int ADDR_W = register_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              w_enable,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] data_addr1,
    input  logic [ADDR_W-1:0] data_addr2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   mem_q [NUM_REGS];
    logic [NUM_REGS-1:0] wrSel_d;

    // One-hot write select; the zero register is never selected.
    always_comb begin
        wrSel_d = '0;
        if (w_enable && (data_addr != ADDR_W'(ZERO_REG))) begin
            wrSel_d[data_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wrSel_d[i]) begin
                    mem_q[i] <= data_in;
                end
            end
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .rst_n_i   (reset),
        .entries_i (mem_q),
        .addr_i    (data_addr1),
        .data_o    (data_out1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .rst_n_i   (reset),
        .entries_i (mem_q),
        .addr_i    (data_addr2),
        .data_o    (data_out2)
    );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read data, a monitor compares.
module tb_register_file;

    typedef struct {
        string       name;
        int          port;
        logic [31:0] expData;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        w_enable = 1'b0;
    logic [4:0]  data_addr = '0;
    logic [31:0] data_in = '0;
    logic [4:0]  data_addr1 = '0;
    logic [4:0]  data_addr2 = '0;
    logic [31:0] data_out1;
    logic [31:0] data_out2;

    expect_t sbQ[$];
    logic    sampleReq = 1'b0;
    int      checkCount = 0;
    int      errorCount = 0;

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .w_enable   (w_enable),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_addr1 (data_addr1),
        .data_addr2 (data_addr2),
        .data_out1  (data_out1),
        .data_out2  (data_out2)
    );

    always #5 clk = ~clk;

    // Monitor: drains every queued expectation whenever the stimulus signals a sample point.
    always @(sampleReq) begin
        while (sbQ.size() > 0) begin
            expect_t e;
            logic [31:0] act;
            e = sbQ.pop_front();
            act = (e.port == 1) ? data_out1 : data_out2;
            checkCount++;
            if (act !== e.expData) begin
                errorCount++;
                $display("[TB] FAIL %s port%0d: got %08h expected %08h", e.name, e.port, act, e.expData);
            end
        end
    end

    task automatic expectOut(input string name, input int port, input logic [31:0] value);
        expect_t e;
        e.name = name;
        e.port = port;
        e.expData = value;
        sbQ.push_back(e);
    endtask

    task automatic checkOutput();
        #1;
        sampleReq = ~sampleReq;
        #1;
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data, input logic en);
        @(negedge clk);
        w_enable  = en;
        data_addr = addr;
        data_in   = data;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
    endtask

    task automatic readBoth(input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2, input string name);
        data_addr1 = a1;
        data_addr2 = a2;
        expectOut(name, 1, e1);
        expectOut(name, 2, e2);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held low with a write attempted: it must be suppressed.
        w_enable  = 1'b1;
        data_addr = 5'd3;
        data_in   = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        readBoth(5'd3, 5'd3, 32'h0, 32'h0, "read_during_reset");
        w_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int a = 0; a < 32; a++) begin
            readBoth(5'(a), 5'(31 - a), 32'h0, 32'h0, "reset_all_zero");
        end

        // First write right after release.
        applyStimulus(5'd4, 32'hFFFFFFFF, 1'b1);
        readBoth(5'd5, 5'd4, 32'h0, 32'hFFFFFFFF, "basic_write");

        data_addr1 = 5'd7;
        applyStimulus(5'd7, 32'h12345678, 1'b0);
        applyStimulus(5'd7, 32'h12345678, 1'b0);
        applyStimulus(5'd7, 32'h12345678, 1'b0);
        readBoth(5'd7, 5'd4, 32'h0, 32'hFFFFFFFF, "enable_gating");

        applyStimulus(5'd0, 32'hFFFFFFFF, 1'b1);
        readBoth(5'd0, 5'd0, 32'h0, 32'h0, "zero_register");

        applyStimulus(5'd31, 32'hA5A5A5A5, 1'b1);
        applyStimulus(5'd1, 32'h5A5A5A5A, 1'b1);
        readBoth(5'd31, 5'd1, 32'hA5A5A5A5, 32'h5A5A5A5A, "dual_read");
        readBoth(5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5, "same_addr_read");

        // Same-address write/read: old value before the edge, new value after.
        @(negedge clk);
        data_addr1 = 5'd9;
        data_addr2 = 5'd9;
        w_enable   = 1'b1;
        data_addr  = 5'd9;
        data_in    = 32'hDEADBEEF;
        readBoth(5'd9, 5'd9, 32'h0, 32'h0, "no_bypass_before_edge");
        @(posedge clk);
        #1;
        w_enable = 1'b0;
        readBoth(5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, "write_after_edge");

        // Back-to-back writes on consecutive cycles.
        applyStimulus(5'd10, 32'h00000001, 1'b1);
        applyStimulus(5'd11, 32'h80000000, 1'b1);
        applyStimulus(5'd10, 32'h0000BEEF, 1'b1);
        readBoth(5'd10, 5'd11, 32'h0000BEEF, 32'h80000000, "back_to_back");

        // Asynchronous reset between edges.
        @(negedge clk);
        #2;
        data_addr2 = 5'd4;
        reset = 1'b0;
        expectOut("async_reset_immediate", 2, 32'h0);
        checkOutput();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        readBoth(5'd31, 5'd4, 32'h0, 32'h0, "stays_zero_after_reset");
        applyStimulus(5'd4, 32'h0F0F0F0F, 1'b1);
        readBoth(5'd1, 5'd4, 32'h0, 32'h0F0F0F0F, "rewrite_after_reset");

        // Reset asserted in the same cycle as a write wins.
        @(negedge clk);
        w_enable  = 1'b1;
        data_addr = 5'd20;
        data_in   = 32'h13579BDF;
        reset     = 1'b0;
        @(posedge clk);
        #1;
        w_enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        readBoth(5'd20, 5'd4, 32'h0, 32'h0, "reset_wins_write");

        for (int i = 0; i < 10 && sbQ.size() != 0; i++) #1;
        if (sbQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
